// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame sequencer.
// Holds the sequencer state encoding, the RGB565 field layout and the colour expansion.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_LATCH
  } led_seq_state_t;

  localparam int unsigned RGB565_WIDTH  = 16;
  localparam int unsigned CHANNEL_WIDTH = 8;

  localparam int unsigned RGB565_R_MSB = 15;
  localparam int unsigned RGB565_R_LSB = 11;
  localparam int unsigned RGB565_G_MSB = 10;
  localparam int unsigned RGB565_G_LSB = 5;
  localparam int unsigned RGB565_B_MSB = 4;
  localparam int unsigned RGB565_B_LSB = 0;

  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] red;
    logic [CHANNEL_WIDTH-1:0] green;
    logic [CHANNEL_WIDTH-1:0] blue;
  } rgb888_t;

  // Widen each field by repeating its top bits so full-scale stays full-scale.
  function automatic rgb888_t rgb565_to_rgb888(input logic [RGB565_WIDTH-1:0] c);
    rgb888_t px;
    px.red   = {c[RGB565_R_MSB:RGB565_R_LSB], c[RGB565_R_MSB -: 3]};
    px.green = {c[RGB565_G_MSB:RGB565_G_LSB], c[RGB565_G_MSB -: 2]};
    px.blue  = {c[RGB565_B_MSB:RGB565_B_LSB], c[RGB565_B_MSB -: 3]};
    return px;
  endfunction

endpackage

// File: rtl/led_latch_timer.sv
// Loadable down-counter timing the line-latch gap.
// done is registered and is high during the last of the CYCLES counted cycles.
module led_latch_timer #(
  parameter int unsigned CYCLES = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int unsigned CNT_WIDTH = $clog2(CYCLES + 1);

  logic [CNT_WIDTH-1:0] count;

  // count holds the number of gap cycles still to run, including the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= CNT_WIDTH'(CYCLES);
      done  <= (CYCLES == 1);
    end else begin
      if (count != '0) begin
        count <= count - 1'b1;
      end
      done <= (32'(count) == 32'd2);
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks the LED colour buffer once per frame and streams expanded RGB888 to the LED driver,
// then holds the latch gap before signalling frame_done.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS           = 50,
  parameter int unsigned LED_ADDRESS_WIDTH  = 10,
  parameter int unsigned CAMERA_COLOR_WIDTH = 16,
  parameter int unsigned RAM_READ_LATENCY   = 2,
  parameter int unsigned LATCH_CYCLES       = 5000
) (
  input  logic                          clk_led,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          refresh_enable,
  output logic [LED_ADDRESS_WIDTH-1:0]  next_led_request_address,
  input  logic [CAMERA_COLOR_WIDTH-1:0] color_data,
  output logic [7:0]                    red_out,
  output logic [7:0]                    green_out,
  output logic [7:0]                    blue_out,
  output logic                          color_valid,
  input  logic                          color_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned LAT_WIDTH = (RAM_READ_LATENCY > 0) ? $clog2(RAM_READ_LATENCY + 1) : 1;
  localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_ADDRESS = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
  localparam logic [LAT_WIDTH-1:0]         LAT_LAST     = LAT_WIDTH'(RAM_READ_LATENCY);

  led_seq_state_t               state;
  led_seq_state_t               state_next;
  logic [LED_ADDRESS_WIDTH-1:0] address_next;
  logic [LAT_WIDTH-1:0]         lat_cnt;
  logic [LAT_WIDTH-1:0]         lat_next;
  logic                         pending;
  logic                         pending_next;
  logic                         capture;
  logic                         latch_load;
  rgb888_t                      pixel;

  assign pixel = rgb565_to_rgb888(RGB565_WIDTH'(color_data));

  led_latch_timer #(
    .CYCLES (LATCH_CYCLES)
  ) u_latch_timer (
    .clk   (clk_led),
    .rst_n (rst_n),
    .load  (latch_load),
    .done  (frame_done)
  );

  // Next-state logic; frame_done doubles as the "last latch cycle" marker.
  always_comb begin
    state_next   = state;
    address_next = next_led_request_address;
    lat_next     = lat_cnt;
    pending_next = pending;
    capture      = 1'b0;
    latch_load   = 1'b0;

    if (frame_start && (state != ST_IDLE)) begin
      pending_next = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (frame_start || refresh_enable) begin
          state_next   = ST_FETCH;
          address_next = '0;
          lat_next     = '0;
          pending_next = 1'b0;
        end
      end

      ST_FETCH: begin
        if (lat_cnt == LAT_LAST) begin
          capture    = 1'b1;
          lat_next   = '0;
          state_next = ST_PRESENT;
        end else begin
          lat_next = lat_cnt + 1'b1;
        end
      end

      ST_PRESENT: begin
        if (color_ready) begin
          if (next_led_request_address == LAST_ADDRESS) begin
            state_next = ST_LATCH;
            latch_load = 1'b1;
          end else begin
            address_next = next_led_request_address + 1'b1;
            lat_next     = '0;
            state_next   = ST_FETCH;
          end
        end
      end

      ST_LATCH: begin
        if (frame_done) begin
          // A start arriving alongside frame_done still chains the next frame.
          if (refresh_enable || pending || frame_start) begin
            state_next   = ST_FETCH;
            address_next = '0;
            lat_next     = '0;
          end else begin
            state_next = ST_IDLE;
          end
          pending_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_led) begin
    if (!rst_n) begin
      state                    <= ST_IDLE;
      next_led_request_address <= '0;
      lat_cnt                  <= '0;
      pending                  <= 1'b0;
      red_out                  <= '0;
      green_out                <= '0;
      blue_out                 <= '0;
      color_valid              <= 1'b0;
      busy                     <= 1'b0;
    end else begin
      state                    <= state_next;
      next_led_request_address <= address_next;
      lat_cnt                  <= lat_next;
      pending                  <= pending_next;
      color_valid              <= (state_next == ST_PRESENT);
      busy                     <= (state_next != ST_IDLE);
      if (capture) begin
        red_out   <= pixel.red;
        green_out <= pixel.green;
        blue_out  <= pixel.blue;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer with a 2-cycle RAM model and a
// behavioural colour model; a negedge monitor checks every accepted LED.
module tb_led_frame_sequencer;

  localparam int unsigned NUM_LEDS     = 4;
  localparam int unsigned AW           = 10;
  localparam int unsigned LAT          = 2;
  localparam int unsigned LATCH        = 8;
  localparam int          FRAME_CYCLES = NUM_LEDS * (LAT + 2) + LATCH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
  } exp_t;

  logic          clk_led;
  logic          rst_n;
  logic          frame_start;
  logic          refresh_enable;
  logic [AW-1:0] next_led_request_address;
  logic [15:0]   color_data;
  logic [7:0]    red_out;
  logic [7:0]    green_out;
  logic [7:0]    blue_out;
  logic          color_valid;
  logic          color_ready;
  logic          busy;
  logic          frame_done;

  logic [15:0] mem [NUM_LEDS];
  logic [15:0] ram_stage;
  exp_t        sb [$];

  int checks;
  int errors;
  int cyc;
  int done_count;

  led_frame_sequencer #(
    .NUM_LEDS           (NUM_LEDS),
    .LED_ADDRESS_WIDTH  (AW),
    .CAMERA_COLOR_WIDTH (16),
    .RAM_READ_LATENCY   (LAT),
    .LATCH_CYCLES       (LATCH)
  ) dut (
    .clk_led                  (clk_led),
    .rst_n                    (rst_n),
    .frame_start              (frame_start),
    .refresh_enable           (refresh_enable),
    .next_led_request_address (next_led_request_address),
    .color_data               (color_data),
    .red_out                  (red_out),
    .green_out                (green_out),
    .blue_out                 (blue_out),
    .color_valid              (color_valid),
    .color_ready              (color_ready),
    .busy                     (busy),
    .frame_done               (frame_done)
  );

  initial begin
    clk_led = 1'b0;
    forever #5 clk_led = ~clk_led;
  end

  initial cyc = 0;
  always @(posedge clk_led) cyc <= cyc + 1;

  // Output-registered RAM: address in cycle t, data valid in cycle t+2.
  always @(posedge clk_led) begin
    ram_stage  <= mem[next_led_request_address[1:0]];
    color_data <= ram_stage;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference expansion: scale each field to 8 bits by shifting and refilling low bits.
  function automatic exp_t model(input int a, input logic [15:0] c);
    exp_t e;
    int r5, g6, b5;
    r5 = int'(c) / 2048;
    g6 = (int'(c) / 32) % 64;
    b5 = int'(c) % 32;
    e.addr = AW'(a);
    e.r    = 8'(r5 * 8 + r5 / 4);
    e.g    = 8'(g6 * 4 + g6 / 16);
    e.b    = 8'(b5 * 8 + b5 / 4);
    return e;
  endfunction

  // Monitor: scoreboard pops on handshake plus protocol rules.
  logic          prev_valid, prev_ready, prev_rst, prev_done;
  logic [AW-1:0] prev_addr;
  logic [23:0]   prev_rgb;
  initial done_count = 0;
  always @(negedge clk_led) begin
    exp_t e;
    if (rst_n === 1'b1 && color_valid === 1'b1 && color_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_led", {next_led_request_address, red_out, green_out, blue_out}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("led_color", {next_led_request_address, red_out, green_out, blue_out}, e);
      end
    end
    if (prev_rst === 1'b1 && rst_n === 1'b1 && prev_valid === 1'b1 && prev_ready === 1'b0)
      check("hold_under_backpressure", {color_valid, next_led_request_address, red_out, green_out, blue_out},
            {1'b1, prev_addr, prev_rgb});
    if (prev_rst === 1'b1 && rst_n === 1'b1 && prev_valid === 1'b1 && prev_ready === 1'b1)
      check("valid_drops_after_accept", color_valid, 0);
    if (frame_done === 1'b1) begin
      done_count++;
      check("frame_done_single_pulse", prev_done, 0);
      check("frame_done_while_busy", busy, 1);
    end
    prev_valid = color_valid;
    prev_ready = color_ready;
    prev_rst   = rst_n;
    prev_done  = frame_done;
    prev_addr  = next_led_request_address;
    prev_rgb   = {red_out, green_out, blue_out};
  end

  task automatic tick();
    @(posedge clk_led);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NUM_LEDS; i++) sb.push_back(model(i, mem[i]));
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NUM_LEDS; i++) mem[i] = 16'($urandom);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd_ready, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (rnd_ready) color_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (frame_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no frame_done within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  task automatic wait_led(input int a, input bit want_valid);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (next_led_request_address == AW'(a) && color_valid == want_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_led: address %0d valid %0b not reached (cycle %0d)", a, want_valid, cyc);
    end
  endtask

  initial begin
    int at1, at2, at3, rise, d0;
    exp_t e;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    refresh_enable = 1'b0;
    color_ready = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) mem[i] = '0;

    // 1: reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_valid", color_valid, 0);
    check("reset_done", frame_done, 0);
    check("reset_address", next_led_request_address, 0);
    check("reset_rgb", {red_out, green_out, blue_out}, 0);

    // 2: primary colours, ready tied high
    mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F; mem[3] = 16'hFFFF;
    sb.push_back({10'd0, 8'hFF, 8'h00, 8'h00});
    sb.push_back({10'd1, 8'h00, 8'hFF, 8'h00});
    sb.push_back({10'd2, 8'h00, 8'h00, 8'hFF});
    sb.push_back({10'd3, 8'hFF, 8'hFF, 8'hFF});
    color_ready = 1'b1;
    d0 = done_count;
    start_frame();
    check("start_busy", busy, 1);
    check("start_address", next_led_request_address, 0);
    check("start_valid_low", color_valid, 0);
    rise = cyc;
    wait_done(200, 1'b0, at1);
    check("frame_cycles", at1 - rise + 1, FRAME_CYCLES);
    tick();
    check("idle_after_frame", busy, 0);
    check("one_done_per_frame", done_count - d0, 1);
    repeat (3) tick();
    check("frame2_all_consumed", sb.size(), 0);

    // 3: backpressure on LED 1
    randomize_mem();
    push_frame();
    e = model(1, mem[1]);
    start_frame();
    wait_led(1, 1'b0);
    color_ready = 1'b0;
    wait_led(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_led1_stable", {color_valid, next_led_request_address, red_out, green_out, blue_out},
            {1'b1, 10'd1, e.r, e.g, e.b});
      tick();
    end
    color_ready = 1'b1;
    wait_done(200, 1'b0, at1);
    tick();
    check("bp_all_consumed", sb.size(), 0);

    // 4: two starts mid-frame give one extra frame; start alongside frame_done chains another
    randomize_mem();
    push_frame(); push_frame(); push_frame();
    d0 = done_count;
    start_frame();
    repeat (4) tick();
    start_frame();
    repeat (3) tick();
    start_frame();
    wait_done(200, 1'b0, at1);
    wait_done(200, 1'b0, at2);
    check("pending_back_to_back", at2 - at1, FRAME_CYCLES);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("chain_start_address", next_led_request_address, 0);
    wait_done(200, 1'b0, at3);
    check("same_cycle_start_gap", at3 - at2, FRAME_CYCLES);
    repeat (30) tick();
    check("pending_frames_done", done_count - d0, 3);
    check("pending_then_idle", busy, 0);
    check("pending_all_consumed", sb.size(), 0);

    // 5: refresh for three frames
    randomize_mem();
    push_frame(); push_frame(); push_frame();
    d0 = done_count;
    refresh_enable = 1'b1;
    wait_done(200, 1'b0, at1);
    wait_done(200, 1'b0, at2);
    tick();
    refresh_enable = 1'b0;
    wait_done(200, 1'b0, at3);
    check("refresh_gap_1", at2 - at1, FRAME_CYCLES);
    check("refresh_gap_2", at3 - at2, FRAME_CYCLES);
    repeat (30) tick();
    check("refresh_frames", done_count - d0, 3);
    check("refresh_then_idle", busy, 0);
    check("refresh_all_consumed", sb.size(), 0);

    // 6: reset while LED 2 is presented
    randomize_mem();
    push_frame();
    start_frame();
    wait_led(2, 1'b0);
    color_ready = 1'b0;
    wait_led(2, 1'b1);
    check("leds_before_reset", sb.size(), 2);
    rst_n = 1'b0;
    tick();
    check("mid_reset_outputs", {busy, color_valid, frame_done, next_led_request_address, red_out, green_out, blue_out}, 0);
    sb.delete();
    d0 = done_count;
    rst_n = 1'b1;
    color_ready = 1'b1;
    repeat (40) tick();
    check("abandoned_no_done", done_count - d0, 0);
    check("abandoned_idle", busy, 0);
    push_frame();
    start_frame();
    check("restart_address", next_led_request_address, 0);
    wait_done(200, 1'b0, at1);
    tick();
    check("restart_all_consumed", sb.size(), 0);

    // 7: random contents with random backpressure
    for (int f = 0; f < 4; f++) begin
      randomize_mem();
      push_frame();
      color_ready = 1'b1;
      start_frame();
      wait_done(400, 1'b1, at1);
      color_ready = 1'b1;
      repeat (2) tick();
      check("random_frame_idle", busy, 0);
    end
    check("final_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Drives the LED-driver side of the LED color buffer in the `clk_led` domain. On a frame request it walks buffer addresses 0..NUM_LEDS-1 and waits out the RAM read latency for each word. It expands each RGB565 camera word to 8-bit red/green/blue and presents it to the LED driver over a valid/ready handshake. After the last LED it holds the line-latch (reset) gap before reporting the frame done.

## Interface
Parameters:
- NUM_LEDS, 50, LEDs per frame; addresses 0..NUM_LEDS-1
- LED_ADDRESS_WIDTH, 10, width of buffer address
- CAMERA_COLOR_WIDTH, 16, buffer word width, RGB565 packed {R[4:0],G[5:0],B[4:0]}
- RAM_READ_LATENCY, 2, cycles from address to valid buffer data (output-registered RAM)
- LATCH_CYCLES, 5000, idle cycles after last LED (≥50 µs at 100 MHz)

Ports:
- clk_led  in  1  LED driver clock; only clock
- rst_n  in  1  synchronous, active-low reset
- frame_start  in  1  single-cycle request to send one frame
- refresh_enable  in  1  level; when high, frames repeat back-to-back without frame_start
- next_led_request_address  out  LED_ADDRESS_WIDTH  buffer port-B read address
- color_data  in  CAMERA_COLOR_WIDTH  buffer port-B read data
- red_out, green_out, blue_out  out  8 each  expanded color for the driver
- color_valid  out  1  color outputs hold a valid LED
- color_ready  in  1  driver accepts when color_valid && color_ready
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at the end of LATCH

## Operation
- States: IDLE, FETCH, PRESENT, LATCH.
- IDLE → FETCH when frame_start or refresh_enable is high. Address is set to 0.
- FETCH lasts RAM_READ_LATENCY+1 cycles with the address stable. On its last edge, color_data is captured and expanded into the output registers. → PRESENT.
- PRESENT: color_valid=1, outputs frozen until handshake.
  - On handshake, if address==NUM_LEDS-1 → LATCH, otherwise address+1 → FETCH.
- LATCH: counts LATCH_CYCLES cycles with color_valid=0. On the final cycle, frame_done=1.
  - Then → FETCH with address 0 if refresh_enable or a pending start is set; otherwise → IDLE.
- Expansion (bit replication): red={c[15:11],c[15:13]}, green={c[10:5],c[10:9]}, blue={c[4:0],c[4:2]}.
- frame_start while busy sets a single pending flag. Further starts are absorbed into it. The flag clears when the next frame begins.
- color_ready while color_valid=0 is ignored.
- Address counter never exceeds NUM_LEDS-1. LATCH counter width is $clog2(LATCH_CYCLES+1).
- Reset values: state IDLE, address 0, color outputs 0, color_valid 0, busy 0, frame_done 0, pending 0, counters 0.
- rst_n low mid-frame: all of the above take effect at the next edge. The frame is abandoned with no frame_done.

## Timing
- All outputs are registered.
- Let cycle t be the first FETCH cycle:
  - Address is valid in cycle t.
  - color_data is sampled at the edge ending cycle t+RAM_READ_LATENCY.
  - color_valid is high from cycle t+RAM_READ_LATENCY+1.
- The handshake completes in the cycle where both color_valid and color_ready are high. color_valid is low and the new address is driven in the next cycle.
- Minimum per-LED period with ready tied high: RAM_READ_LATENCY+2 cycles.
- frame_start in IDLE at cycle s: busy=1 and address 0 in cycle s+1.
- Minimum frame length: NUM_LEDS·(RAM_READ_LATENCY+2)+LATCH_CYCLES cycles.
- frame_start in the same cycle as frame_done sets pending, so the next frame follows with no IDLE cycle.

## Structure
- Shared package `led_pkg`:
  - state enum `led_seq_state_t`
  - RGB565 field bit positions
  - function `rgb565_to_rgb888`
- One sub-module: `led_latch_timer` (loadable down-counter with done pulse), used for LATCH.
- The address and latency counters stay inline.

## Test plan
The bench uses NUM_LEDS=4, RAM_READ_LATENCY=2, LATCH_CYCLES=8, and a RAM model with 2-cycle latency.

1. Reset then idle, rst_n=0 for 3 cycles, then high, no frame_start → all outputs 0, busy=0, address 0.
2. Single frame with contents 0xF800, 0x07E0, 0x001F, 0xFFFF, color_ready tied high:
   - Required colors in order: (R,G,B)=(FF,00,00), (00,FF,00), (00,00,FF), (FF,FF,FF), each valid exactly 1 cycle.
   - frame_done pulses once, 4·4+8=24 cycles after busy rises; busy=0 afterwards.
3. Backpressure, color_ready low for 5 cycles on LED 1 → color_valid and outputs stay stable for those 5 cycles, address stays 1, and there is no skip or duplicate.
4. frame_start asserted twice mid-frame → exactly one extra frame follows, starting the cycle after frame_done.
5. refresh_enable high for 3 frames, then low → 3 consecutive frames, then IDLE; frame_done pulses 3 times.
6. rst_n low during PRESENT of LED 2 → next cycle all outputs 0, state IDLE, no frame_done. A new frame_start sends all 4 LEDs from address 0.
